clk_enable_gen: RTL and testbench

//   Parametrised multi-channel fractional clock-enable generator. One fabric clock

---
 rtl/clk_enable_gen.sv | 104 ++++++++++
 tb/tb_clk_enable_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per channel,
// carry-out drives a single-cycle enable, with glitch-free rate updates, re-align and lock.
module clk_enable_gen #(
    parameter int unsigned             NUM_CH      = 2,
    parameter int unsigned             ACC_W       = 32,
    parameter int unsigned             LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] INC_RST     = {32'h8000_0000, 32'h4072_B021},
    localparam int unsigned            CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              sync_req,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] phase_out,
    output logic              locked,
    output logic              cfg_err
);

    localparam int unsigned      CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

    logic [ACC_W-1:0]  acc     [NUM_CH];
    logic [ACC_W-1:0]  inc     [NUM_CH];
    logic [ACC_W-1:0]  acc_sum [NUM_CH];
    logic [NUM_CH-1:0] carry;

    logic              pending;
    logic [CH_W-1:0]   pend_ch;
    logic [ACC_W-1:0]  pend_inc;
    logic [CNT_W-1:0]  lock_cnt;

    logic ch_ok;
    logic accept;
    logic apply;

    always_comb begin
        carry   = '0;
        acc_sum = '{default: '0};
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            {carry[i], acc_sum[i]} = {1'b0, acc[i]} + {1'b0, inc[i]};
        end
    end

    assign ch_ok     = (32'(cfg_ch) < NUM_CH);
    assign accept    = cfg_valid && !pending;
    // Swap the rate only at a wrap of the target channel, so the old increment finishes its
    // period and no runt pulse appears; a disabled channel or a re-align swaps immediately.
    assign apply     = pending && (sync_req || carry[pend_ch] || (inc[pend_ch] == '0));
    assign cfg_ready = ~pending;

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                inc[i] <= INC_RST[i*ACC_W +: ACC_W];
            end
            ce_out    <= '0;
            phase_out <= '0;
            pending   <= 1'b0;
            pend_ch   <= '0;
            pend_inc  <= '0;
            lock_cnt  <= '0;
            locked    <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc[i] <= sync_req ? '0 : acc_sum[i];
            end
            if (sync_req) begin
                ce_out    <= '0;
                phase_out <= '0;
            end else begin
                ce_out    <= carry;
                phase_out <= phase_out ^ carry;
            end

            if (apply) begin
                inc[pend_ch] <= pend_inc;
            end

            if (apply) begin
                pending <= 1'b0;
            end else if (accept && ch_ok) begin
                pending  <= 1'b1;
                pend_ch  <= cfg_ch;
                pend_inc <= cfg_inc;
            end

            cfg_err <= accept && !ch_ok;

            if (sync_req || apply || (accept && ch_ok)) begin
                lock_cnt <= '0;
            end else if (lock_cnt != LOCK_MAX) begin
                lock_cnt <= lock_cnt + 1'b1;
            end
            locked <= (lock_cnt == LOCK_MAX) && !pending;
        end
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: default rates, rate updates, disable/enable,
// out-of-range config (3-channel instance), re-align and reset with an update pending.
module tb_clk_enable_gen;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        cfg_valid, cfg_ready, sync_req, locked, cfg_err;
    logic [0:0]  cfg_ch;
    logic [31:0] cfg_inc;
    logic [1:0]  ce_out, phase_out;

    logic        cfg_valid3, cfg_ready3, sync3, locked3, cfg_err3;
    logic [1:0]  cfg_ch3;
    logic [31:0] cfg_inc3;
    logic [2:0]  ce3, ph3;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    clk_enable_gen #(.NUM_CH(2), .ACC_W(32), .LOCK_CYCLES(16),
                     .INC_RST({32'h8000_0000, 32'h4072_B021})) u_dut (
        .clk_in(clk_in), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .sync_req(sync_req), .ce_out(ce_out),
        .phase_out(phase_out), .locked(locked), .cfg_err(cfg_err));

    clk_enable_gen #(.NUM_CH(3), .ACC_W(32), .LOCK_CYCLES(16),
                     .INC_RST({32'h2000_0000, 32'h8000_0000, 32'h4072_B021})) u_dut3 (
        .clk_in(clk_in), .reset_n(reset_n), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
        .cfg_ch(cfg_ch3), .cfg_inc(cfg_inc3), .sync_req(sync3), .ce_out(ce3),
        .phase_out(ph3), .locked(locked3), .cfg_err(cfg_err3));

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        checks++; if (ce_out !== 2'b00) begin failures++; $display("FAIL reset_ce got=%b exp=00", ce_out); end
        checks++; if (phase_out !== 2'b00) begin failures++; $display("FAIL reset_phase got=%b exp=00", phase_out); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    endtask

    task automatic test_defaults;
        int c0 = 0, bad1 = 0, badlk = 0;
        for (int k = 1; k <= 20000; k++) begin
            tick;
            c0 += int'(ce_out[0]);
            if (ce_out[1] !== 1'((k % 2) == 0)) bad1++;
            if (phase_out[1] !== 1'(((k / 2) % 2) == 1)) bad1++;
            if (k <= 16 && locked !== 1'b0) badlk++;
            if (k >= 17 && locked !== 1'b1) badlk++;
        end
        // floor(20000 * 0x4072B021 / 2^32) = 5035
        checks++; if (c0 != 5035) begin failures++; $display("FAIL dflt_ch0_count got=%0d exp=5035", c0); end
        checks++; if (bad1 != 0) begin failures++; $display("FAIL dflt_ch1_pattern errors=%0d exp=0", bad1); end
        checks++; if (badlk != 0) begin failures++; $display("FAIL dflt_locked errors=%0d exp=0", badlk); end
    endtask

    task automatic test_ch0_update;
        logic prev1;
        int   bad1 = 0, badrdy = 0, bad0 = 0, badlk = 0;
        bit   found = 0;
        prev1     = ce_out[1];
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 32'h4000_0000;
        tick;
        cfg_valid = 1'b0;
        if (ce_out[1] !== ~prev1) bad1++;
        prev1 = ce_out[1];
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL upd_ready_accept got=%b exp=0", cfg_ready); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL upd_locked_accept got=%b exp=1", locked); end
        for (int k = 0; k < 8 && !found; k++) begin
            tick;
            if (ce_out[1] !== ~prev1) bad1++;
            prev1 = ce_out[1];
            if (k == 0) begin
                checks++; if (locked !== 1'b0) begin failures++; $display("FAIL upd_locked_drop got=%b exp=0", locked); end
            end
            if (ce_out[0] === 1'b1) found = 1;
            else if (cfg_ready !== 1'b0) badrdy++;
        end
        checks++; if (!found) begin failures++; $display("FAIL upd_wait_pulse got=timeout exp=ch0 pulse"); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL upd_ready_apply got=%b exp=1", cfg_ready); end
        checks++; if (badrdy != 0) begin failures++; $display("FAIL upd_ready_pending errors=%0d exp=0", badrdy); end
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (ce_out[1] !== ~prev1) bad1++;
            prev1 = ce_out[1];
            if (ce_out[0] !== 1'((k % 4) == 0)) bad0++;
            if (locked !== 1'(k >= 17)) badlk++;
        end
        checks++; if (bad0 != 0) begin failures++; $display("FAIL upd_ch0_period4 errors=%0d exp=0", bad0); end
        checks++; if (badlk != 0) begin failures++; $display("FAIL upd_relock errors=%0d exp=0", badlk); end
        checks++; if (bad1 != 0) begin failures++; $display("FAIL upd_ch1_undisturbed errors=%0d exp=0", bad1); end
    endtask

    task automatic test_ch1_disable;
        logic ph_hold;
        int   bad = 0;
        bit   found = 0;
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 32'h0;
        tick;
        cfg_valid = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            tick;
            if (cfg_ready === 1'b1) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL dis_apply got=timeout exp=ready"); end
        ph_hold = phase_out[1];
        for (int k = 0; k < 10; k++) begin
            tick;
            if (ce_out[1] !== 1'b0 || phase_out[1] !== ph_hold) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL dis_ch1_stopped errors=%0d exp=0", bad); end
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 32'h8000_0000;
        tick;
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL en_ready_accept got=%b exp=0", cfg_ready); end
        tick;
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL en_apply_1cyc got=%b exp=1", cfg_ready); end
        bad = 0;
        if (ce_out[1] !== 1'b0) bad++;
        tick; if (ce_out[1] !== 1'b0) bad++;
        tick; if (ce_out[1] !== 1'b1) bad++;
        tick; if (ce_out[1] !== 1'b0) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL en_ch1_restart errors=%0d exp=0", bad); end
        for (int k = 0; k < 20; k++) tick;
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL en_relock got=%b exp=1", locked); end
    endtask

    task automatic test_bad_channel;
        int  bad = 0;
        bit  found = 0;
        logic prev1;
        checks++; if (locked3 !== 1'b1) begin failures++; $display("FAIL err_locked_before got=%b exp=1", locked3); end
        cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_inc3 = 32'h1234_5678;
        tick;
        cfg_valid3 = 1'b0;
        checks++; if (cfg_err3 !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", cfg_err3); end
        checks++; if (cfg_ready3 !== 1'b1) begin failures++; $display("FAIL err_ready got=%b exp=1", cfg_ready3); end
        tick;
        checks++; if (cfg_err3 !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b exp=0", cfg_err3); end
        checks++; if (locked3 !== 1'b1) begin failures++; $display("FAIL err_locked_kept got=%b exp=1", locked3); end
        checks++; if (cfg_ready3 !== 1'b1) begin failures++; $display("FAIL err_ready_kept got=%b exp=1", cfg_ready3); end
        for (int k = 0; k < 9 && !found; k++) begin
            tick;
            if (ce3[2] === 1'b1) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL err_ch2_pulse got=timeout exp=pulse"); end
        prev1 = ce3[1];
        for (int k = 1; k <= 16; k++) begin
            tick;
            if (ce3[2] !== 1'((k % 8) == 0)) bad++;
            if (ce3[1] !== ~prev1) bad++;
            prev1 = ce3[1];
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL err_inc_unchanged errors=%0d exp=0", bad); end
    endtask

    task automatic test_sync;
        int bad = 0;
        bit found = 0;
        for (int k = 0; k < 6 && !found; k++) begin
            tick;
            if (ce_out[0] === 1'b1) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL sync_wait_ch0 got=timeout exp=pulse"); end
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 32'h1000_0000;
        tick;
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL sync_pending got=%b exp=0", cfg_ready); end
        // line sync up with a ch1 carry edge so the re-align must override that pulse
        if (ce_out[1] === 1'b1) tick;
        sync_req = 1'b1;
        tick;
        sync_req = 1'b0;
        checks++; if (ce_out !== 2'b00) begin failures++; $display("FAIL sync_ce got=%b exp=00", ce_out); end
        checks++; if (phase_out !== 2'b00) begin failures++; $display("FAIL sync_phase got=%b exp=00", phase_out); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL sync_applied got=%b exp=1", cfg_ready); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL sync_locked got=%b exp=0", locked); end
        for (int k = 1; k <= 16; k++) begin
            tick;
            if (ce_out[0] !== 1'(k == 16) || phase_out[0] !== 1'(k == 16)) bad++;
            if (ce_out[1] !== 1'((k % 2) == 0)) bad++;
            if (phase_out[1] !== 1'(((k / 2) % 2) == 1)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL sync_realign errors=%0d exp=0", bad); end
    endtask

    task automatic test_reset_pending;
        int bad = 0;
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 32'h0800_0000;
        tick;
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rstp_pending got=%b exp=0", cfg_ready); end
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rstp_ready got=%b exp=1", cfg_ready); end
        checks++; if (ce_out !== 2'b00 || phase_out !== 2'b00) begin failures++; $display("FAIL rstp_outputs got=%b/%b exp=00/00", ce_out, phase_out); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rstp_locked got=%b exp=0", locked); end
        for (int k = 1; k <= 8; k++) begin
            tick;
            if (ce_out[0] !== 1'(k == 4 || k == 8)) bad++;
            if (ce_out[1] !== 1'((k % 2) == 0)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rstp_inc_restored errors=%0d exp=0", bad); end
    endtask

    initial begin
        reset_n    = 1'b0;
        cfg_valid  = 1'b0; cfg_ch  = '0; cfg_inc  = '0; sync_req = 1'b0;
        cfg_valid3 = 1'b0; cfg_ch3 = '0; cfg_inc3 = '0; sync3    = 1'b0;
        test_reset;
        test_defaults;
        test_ch0_update;
        test_ch1_disable;
        test_bad_channel;
        test_sync;
        test_reset_pending;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
